// File: rtl/iir_ctrl_pkg.sv
// Shared types for the IIR coefficient controller: FSM states, config addresses, default width.
package iir_ctrl_pkg;

  localparam int NB_DEF = 12;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    SWAP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ADDR_B0  = 2'd0,
    ADDR_B1  = 2'd1,
    ADDR_A1  = 2'd2,
    ADDR_RSV = 2'd3
  } cfg_addr_e;

endpackage

// File: rtl/iir_occ_cnt.sv
// Saturating up/down counter of samples inside the filter pipeline; exposes only an empty flag.
module iir_occ_cnt #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/iir_coef_ctrl.sv
// Coefficient bank controller for an IIR filter: registers samples towards the filter and swaps the
// shadow coefficient bank into the active bank only once the filter pipeline has drained.
module iir_coef_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int NB       = NB_DEF,
  parameter int OCC_W    = 4,
  parameter int DRAIN_TO = 15,
  parameter int CLR_CYC  = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  output logic          IN_RDY,
  input  logic          CFG_WE,
  input  logic [1:0]    CFG_ADDR,
  input  logic [NB-1:0] CFG_DATA,
  input  logic          CFG_COMMIT,
  input  logic          CFG_CLR,
  output logic          CFG_BUSY,
  output logic [NB-1:0] F_DIN,
  output logic          F_VIN,
  input  logic          F_VOUT,
  output logic          F_RST_n,
  output logic [NB-1:0] b0,
  output logic [NB-1:0] b1,
  output logic [NB-1:0] a1,
  output logic [15:0]   SAMPLE_CNT,
  output logic          DRAIN_ERR
);

  localparam int CYC_W = 8;

  typedef struct packed {
    logic [NB-1:0] b0;
    logic [NB-1:0] b1;
    logic [NB-1:0] a1;
  } bank_t;

  state_e           state_q, state_d;
  logic             clr_pend_q, clr_pend_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  bank_t            shadow_q, shadow_d;
  bank_t            active_q, active_d;
  logic             in_rdy_q, in_rdy_d;
  logic             f_vin_q, f_vin_d;
  logic [NB-1:0]    f_din_q, f_din_d;
  logic             f_rst_n_q, f_rst_n_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;
  logic             drain_err_q, drain_err_d;

  logic occ_zero;
  logic transfer;
  logic drain_clean;
  logic drain_tmo;

  iir_occ_cnt #(.W(OCC_W)) u_occ (
    .clk  (CLK),
    .rst  (RST),
    .inc  (f_vin_q),
    .dec  (F_VOUT),
    .clr  (state_q == CLEAR),
    .zero (occ_zero)
  );

  assign transfer    = VIN & in_rdy_q;
  // A sample still sitting in the output register is not yet counted in occupancy.
  assign drain_clean = occ_zero && !f_vin_q;
  assign drain_tmo   = (cyc_q == CYC_W'(DRAIN_TO - 1));

  // NOTE: every signal gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    clr_pend_d  = clr_pend_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    drain_err_d = drain_err_q;

    if (CFG_WE) begin
      case (cfg_addr_e'(CFG_ADDR))
        ADDR_B0: shadow_d.b0 = CFG_DATA;
        ADDR_B1: shadow_d.b1 = CFG_DATA;
        ADDR_A1: shadow_d.a1 = CFG_DATA;
        default: ;
      endcase
    end

    case (state_q)
      RUN: begin
        if (CFG_COMMIT) begin
          state_d    = DRAIN;
          clr_pend_d = CFG_CLR;
        end
      end
      DRAIN: begin
        if (drain_clean || drain_tmo) begin
          state_d = clr_pend_q ? CLEAR : SWAP;
          if (!drain_clean) drain_err_d = 1'b1;
        end
      end
      CLEAR: begin
        if (cyc_q == CYC_W'(CLR_CYC - 1)) state_d = SWAP;
      end
      SWAP: begin
        // Reads the registered shadow, so a write landing this cycle waits for the next commit.
        active_d = shadow_q;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase

    cyc_d = (state_d == state_q && state_q != RUN) ? cyc_q + 1'b1 : '0;

    in_rdy_d     = (state_d == RUN);
    f_rst_n_d    = (state_d != CLEAR);
    f_vin_d      = transfer;
    f_din_d      = DIN;
    sample_cnt_d = sample_cnt_q + 16'(transfer);
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values regardless of order.
  // NOTE: both coefficient banks are reset because the active bank drives the filter directly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      clr_pend_q   <= 1'b0;
      cyc_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      in_rdy_q     <= 1'b0;
      f_vin_q      <= 1'b0;
      f_din_q      <= '0;
      f_rst_n_q    <= 1'b0;
      sample_cnt_q <= '0;
      drain_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_pend_q   <= clr_pend_d;
      cyc_q        <= cyc_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      in_rdy_q     <= in_rdy_d;
      f_vin_q      <= f_vin_d;
      f_din_q      <= f_din_d;
      f_rst_n_q    <= f_rst_n_d;
      sample_cnt_q <= sample_cnt_d;
      drain_err_q  <= drain_err_d;
    end
  end

  assign IN_RDY     = in_rdy_q;
  assign CFG_BUSY   = (state_q != RUN);
  assign F_DIN      = f_din_q;
  assign F_VIN      = f_vin_q;
  assign F_RST_n    = f_rst_n_q;
  assign b0         = active_q.b0;
  assign b1         = active_q.b1;
  assign a1         = active_q.a1;
  assign SAMPLE_CNT = sample_cnt_q;
  assign DRAIN_ERR  = drain_err_q;

endmodule
